// File: rtl/dispatch_nway.sv
// rtl/dispatch_nway.sv - in-order N-wide dispatch buffer with per-channel RS credits
// Define DISPATCH_PERF_EN to add saturating lane-0 stall-reason counters.
module dispatch_nway #(
   parameter int WIDTH     = 2,
   parameter int NUM_RS    = 5,
   parameter int RS_DEPTH  = 8,
   parameter int BUF_DEPTH = 4,
   parameter int ROB_IDX_W = 5,
   parameter int PAYLOAD_W = 96,
   localparam int RS_SEL_W = $clog2(NUM_RS),
   localparam int CNT_W    = $clog2(RS_DEPTH + 1),
   localparam int DC_W     = $clog2(WIDTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              in_valid,
   input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
   input  logic [WIDTH*RS_SEL_W-1:0]     in_rs_sel,
   input  logic [WIDTH-1:0]              in_needs_pd,
   output logic                          in_ready,
   input  logic [ROB_IDX_W:0]            rob_free_cnt,
   input  logic [ROB_IDX_W-1:0]          rob_tail,
   input  logic [DC_W-1:0]               fl_avail,
   input  logic [NUM_RS-1:0]             rs_release,
   output logic [WIDTH-1:0]              disp_valid,
   output logic [WIDTH*PAYLOAD_W-1:0]    disp_payload,
   output logic [WIDTH*RS_SEL_W-1:0]     disp_rs_sel,
   output logic [WIDTH*ROB_IDX_W-1:0]    disp_rob_idx,
   output logic [DC_W-1:0]               disp_cnt,
   output logic [DC_W-1:0]               fl_pop_cnt,
`ifdef DISPATCH_PERF_EN
   output logic [31:0]                   perf_rob_stall,
   output logic [31:0]                   perf_rs_stall,
   output logic [31:0]                   perf_fl_stall,
`endif
   output logic                          dispatch_stall
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int BC_W  = $clog2(BUF_DEPTH + 1);

   logic [PAYLOAD_W-1:0] pay_q [BUF_DEPTH];
   logic [PAYLOAD_W-1:0] pay_d [BUF_DEPTH];
   logic [RS_SEL_W-1:0]  sel_q [BUF_DEPTH];
   logic [RS_SEL_W-1:0]  sel_d [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] pd_q, pd_d;
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [BC_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]     credit_q [NUM_RS];
   logic [CNT_W-1:0]     credit_d [NUM_RS];

   logic [PTR_W-1:0]     lane_idx [WIDTH];
   logic [RS_SEL_W-1:0]  lane_sel [WIDTH];
   logic [CNT_W-1:0]     lane_cred [WIDTH];
   int                   disp_to [NUM_RS];
   int                   n_disp, n_pd, n_enq, same, cred_tmp;
   logic                 chain;
   logic [PTR_W-1:0]     wr_idx;

   assign in_ready = (BUF_DEPTH - int'(count_q)) >= WIDTH;

   // Lane k may go only if every older lane goes; chain drops at the first blocked lane.
   always_comb begin
      disp_valid   = '0;
      disp_payload = '0;
      disp_rs_sel  = '0;
      disp_rob_idx = '0;
      n_disp       = 0;
      n_pd         = 0;
      same         = 0;
      chain        = !flush;
      for (int c = 0; c < NUM_RS; c++) disp_to[c] = 0;
      for (int k = 0; k < WIDTH; k++) begin
         lane_idx[k]  = head_q + PTR_W'(k);
         lane_sel[k]  = sel_q[lane_idx[k]];
         lane_cred[k] = '0;
         for (int c = 0; c < NUM_RS; c++)
            if (int'(lane_sel[k]) == c) lane_cred[k] = credit_q[c];
         same = 0;
         for (int j = 0; j < k; j++)
            if (lane_sel[j] == lane_sel[k]) same++;
         disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[lane_idx[k]];
         disp_rs_sel[k*RS_SEL_W +: RS_SEL_W]    = lane_sel[k];
         disp_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] = rob_tail + ROB_IDX_W'(k);
         if (chain && (k < int'(count_q)) && (k + 1 <= int'(rob_free_cnt))
             && (n_pd + int'(pd_q[lane_idx[k]]) <= int'(fl_avail))
             && (int'(lane_cred[k]) > same)) begin
            disp_valid[k] = 1'b1;
            n_disp        = n_disp + 1;
            n_pd          = n_pd + int'(pd_q[lane_idx[k]]);
            for (int c = 0; c < NUM_RS; c++)
               if (int'(lane_sel[k]) == c) disp_to[c] = disp_to[c] + 1;
         end else begin
            chain = 1'b0;
         end
      end
      disp_cnt       = DC_W'(n_disp);
      fl_pop_cnt     = DC_W'(n_pd);
      dispatch_stall = (count_q != '0) && (n_disp == 0);
   end

   always_comb begin
      pay_d    = pay_q;
      sel_d    = sel_q;
      pd_d     = pd_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      n_enq    = 0;
      cred_tmp = 0;
      wr_idx   = '0;
      for (int c = 0; c < NUM_RS; c++) credit_d[c] = credit_q[c];
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int c = 0; c < NUM_RS; c++) credit_d[c] = CNT_W'(RS_DEPTH);
      end else begin
         for (int k = 0; k < WIDTH; k++) begin
            if (in_ready && in_valid[k]) begin
               wr_idx        = tail_q + PTR_W'(k);
               pay_d[wr_idx] = in_payload[k*PAYLOAD_W +: PAYLOAD_W];
               sel_d[wr_idx] = in_rs_sel[k*RS_SEL_W +: RS_SEL_W];
               pd_d[wr_idx]  = in_needs_pd[k];
               n_enq         = n_enq + 1;
            end
         end
         tail_d  = tail_q + PTR_W'(n_enq);
         head_d  = head_q + PTR_W'(n_disp);
         count_d = BC_W'(int'(count_q) + n_enq - n_disp);
         for (int c = 0; c < NUM_RS; c++) begin
            cred_tmp = int'(credit_q[c]) - disp_to[c] + int'(rs_release[c]);
            if (cred_tmp > RS_DEPTH) cred_tmp = RS_DEPTH;
            credit_d[c] = CNT_W'(cred_tmp);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            pay_q[i] <= '0;
            sel_q[i] <= '0;
         end
         pd_q    <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int c = 0; c < NUM_RS; c++) credit_q[c] <= CNT_W'(RS_DEPTH);
      end else begin
         pay_q    <= pay_d;
         sel_q    <= sel_d;
         pd_q     <= pd_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         credit_q <= credit_d;
      end
   end

   // A release into a full-credit channel means RS and dispatch disagree on occupancy.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_RS; c++)
         if (rst_n && !flush && rs_release[c] && credit_q[c] == CNT_W'(RS_DEPTH))
            assert (disp_to[c] != 0);
   end

`ifdef DISPATCH_PERF_EN
   logic [31:0] perf_rob_q, perf_rob_d, perf_rs_q, perf_rs_d, perf_fl_q, perf_fl_d;

   always_comb begin
      perf_rob_d = perf_rob_q;
      perf_rs_d  = perf_rs_q;
      perf_fl_d  = perf_fl_q;
      if (!flush && count_q != '0 && !disp_valid[0]) begin
         if (rob_free_cnt == '0) begin
            if (perf_rob_q != '1) perf_rob_d = perf_rob_q + 32'd1;
         end else if (lane_cred[0] == '0) begin
            if (perf_rs_q != '1) perf_rs_d = perf_rs_q + 32'd1;
         end else begin
            if (perf_fl_q != '1) perf_fl_d = perf_fl_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_rob_q <= '0;
         perf_rs_q  <= '0;
         perf_fl_q  <= '0;
      end else begin
         perf_rob_q <= perf_rob_d;
         perf_rs_q  <= perf_rs_d;
         perf_fl_q  <= perf_fl_d;
      end
   end

   assign perf_rob_stall = perf_rob_q;
   assign perf_rs_stall  = perf_rs_q;
   assign perf_fl_stall  = perf_fl_q;
`endif
endmodule

// File: tb/tb_dispatch_nway.sv
// tb/tb_dispatch_nway.sv - directed bench for dispatch_nway
module tb_dispatch_nway;
   localparam int PW = 96;

   logic          clk = 1'b0;
   logic          rst_n, flush;
   logic [1:0]    in_valid, in_needs_pd;
   logic [191:0]  in_payload;
   logic [5:0]    in_rs_sel;
   logic          in_ready;
   logic [5:0]    rob_free_cnt;
   logic [4:0]    rob_tail;
   logic [1:0]    fl_avail;
   logic [4:0]    rs_release;
   logic [1:0]    disp_valid, disp_cnt, fl_pop_cnt;
   logic [191:0]  disp_payload;
   logic [5:0]    disp_rs_sel;
   logic [9:0]    disp_rob_idx;
   logic          dispatch_stall;
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   dispatch_nway dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_payload(in_payload), .in_rs_sel(in_rs_sel), .in_needs_pd(in_needs_pd),
      .in_ready(in_ready), .rob_free_cnt(rob_free_cnt), .rob_tail(rob_tail),
      .fl_avail(fl_avail), .rs_release(rs_release), .disp_valid(disp_valid),
      .disp_payload(disp_payload), .disp_rs_sel(disp_rs_sel),
      .disp_rob_idx(disp_rob_idx), .disp_cnt(disp_cnt), .fl_pop_cnt(fl_pop_cnt),
      .dispatch_stall(dispatch_stall)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input logic [1:0] v, input logic [2:0] s0, input logic [2:0] s1,
                            input logic [1:0] pd, input int tag);
      in_valid    = v;
      in_rs_sel   = {s1, s0};
      in_needs_pd = pd;
      in_payload  = {PW'(tag + 1), PW'(tag)};
   endtask

   task automatic idle();
      in_valid = 2'b00;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      idle();
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; rs_release = '0; rob_free_cnt = 6'd8; rob_tail = '0;
      fl_avail = 2'd2; in_payload = '0; in_rs_sel = '0; in_needs_pd = '0;
      idle();
      step(); step();
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", disp_valid); end
      n_tests++; if (disp_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", disp_cnt); end
      n_tests++; if (fl_pop_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_flpop: got %0d want 0", fl_pop_cnt); end
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", dispatch_stall); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      rob_tail = 5'd30; rob_free_cnt = 6'd8; fl_avail = 2'd2;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b11, 32'h100);
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_nobypass: got %b want 00", disp_valid); end
      step(); idle();
      n_tests++; if (disp_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b want 11", disp_valid); end
      n_tests++; if (disp_rob_idx !== {5'd31, 5'd30}) begin n_fail++; $display("FAIL basic_robidx: got %h want 3fe", disp_rob_idx); end
      n_tests++; if (disp_cnt !== 2'd2) begin n_fail++; $display("FAIL basic_cnt: got %0d want 2", disp_cnt); end
      n_tests++; if (fl_pop_cnt !== 2'd2) begin n_fail++; $display("FAIL basic_flpop: got %0d want 2", fl_pop_cnt); end
      n_tests++; if (disp_payload[95:0] !== 96'h100) begin n_fail++; $display("FAIL basic_payload: got %h want 100", disp_payload[95:0]); end
      n_tests++; if (disp_rs_sel !== 6'b001001) begin n_fail++; $display("FAIL basic_sel: got %b want 001001", disp_rs_sel); end
      step();
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_drained: got %b want 00", disp_valid); end
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall: got %b want 0", dispatch_stall); end
   endtask

   task automatic test_rob_wrap();
      rob_tail = 5'd31;
      set_lanes(2'b01, 3'd1, 3'd0, 2'b00, 32'h200);
      step(); idle();
      n_tests++; if (disp_valid !== 2'b01) begin n_fail++; $display("FAIL wrap_valid: got %b want 01", disp_valid); end
      n_tests++; if (disp_rob_idx[4:0] !== 5'd31) begin n_fail++; $display("FAIL wrap_idx31: got %0d want 31", disp_rob_idx[4:0]); end
      n_tests++; if (disp_rob_idx[9:5] !== 5'd0) begin n_fail++; $display("FAIL wrap_lane1: got %0d want 0", disp_rob_idx[9:5]); end
      n_tests++; if (disp_cnt !== 2'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", disp_cnt); end
      step();
      rob_tail = 5'd0;
      set_lanes(2'b01, 3'd1, 3'd0, 2'b00, 32'h210);
      step(); idle();
      n_tests++; if (disp_rob_idx[4:0] !== 5'd0) begin n_fail++; $display("FAIL wrap_idx0: got %0d want 0", disp_rob_idx[4:0]); end
      step();
   endtask

   task automatic test_credit();
      int rem = 9;
      int sum = 0;
      do_flush();
      for (int i = 0; i < 14; i++) begin
         sum += int'(disp_cnt);
         if (in_ready && rem >= 2) begin
            set_lanes(2'b11, 3'd3, 3'd3, 2'b00, 32'h1000 + i * 2); rem -= 2;
         end else if (in_ready && rem == 1) begin
            set_lanes(2'b01, 3'd3, 3'd3, 2'b00, 32'h1000 + i * 2); rem = 0;
         end else begin
            idle();
         end
         step();
      end
      idle();
      n_tests++; if (sum != 8) begin n_fail++; $display("FAIL credit_total: got %0d want 8", sum); end
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL credit_block: got %b want 00", disp_valid); end
      n_tests++; if (dispatch_stall !== 1'b1) begin n_fail++; $display("FAIL credit_stall: got %b want 1", dispatch_stall); end
      rs_release = 5'b01000;
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL credit_relcycle: got %b want 00", disp_valid); end
      step(); rs_release = '0;
      n_tests++; if (disp_valid !== 2'b01) begin n_fail++; $display("FAIL credit_after_rel: got %b want 01", disp_valid); end
      n_tests++; if (disp_cnt !== 2'd1) begin n_fail++; $display("FAIL credit_after_cnt: got %0d want 1", disp_cnt); end
      step();
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL credit_empty: got %b want 0", dispatch_stall); end
   endtask

   task automatic test_in_order();
      do_flush();
      for (int i = 0; i < 4; i++) begin
         set_lanes(2'b11, 3'd4, 3'd4, 2'b00, 32'h2000 + i * 2);
         step(); idle(); step();
      end
      set_lanes(2'b11, 3'd2, 3'd4, 2'b00, 32'h300);
      step();
      set_lanes(2'b01, 3'd1, 3'd0, 2'b00, 32'h400);
      #1;
      n_tests++; if (disp_valid !== 2'b01) begin n_fail++; $display("FAIL order_br_only: got %b want 01", disp_valid); end
      step(); idle();
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL order_block: got %b want 00", disp_valid); end
      n_tests++; if (dispatch_stall !== 1'b1) begin n_fail++; $display("FAIL order_stall: got %b want 1", dispatch_stall); end
      n_tests++; if (disp_rs_sel[2:0] !== 3'd4) begin n_fail++; $display("FAIL order_head_sel: got %0d want 4", disp_rs_sel[2:0]); end
   endtask

   task automatic test_flush();
      rob_free_cnt = 6'd0;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b00, 32'h500);
      step(); idle();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", in_ready); end
      flush = 1'b1;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b00, 32'h600);
      step(); flush = 1'b0; idle();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", dispatch_stall); end
      rob_free_cnt = 6'd8;
      set_lanes(2'b11, 3'd4, 3'd4, 2'b00, 32'h800);
      step(); idle();
      n_tests++; if (disp_valid !== 2'b11) begin n_fail++; $display("FAIL flush_credit: got %b want 11", disp_valid); end
      n_tests++; if (disp_payload[95:0] !== 96'h800) begin n_fail++; $display("FAIL flush_payload: got %h want 800", disp_payload[95:0]); end
      step();
      rob_free_cnt = 6'd0;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b00, 32'h900);
      step();
      rob_free_cnt = 6'd8; flush = 1'b1;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b00, 32'hA00);
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_forced: got %b want 00", disp_valid); end
      n_tests++; if (disp_cnt !== 2'd0) begin n_fail++; $display("FAIL flush_forced_cnt: got %0d want 0", disp_cnt); end
      step(); flush = 1'b0; idle();
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_discard: got %b want 00", disp_valid); end
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL flush_discard_stall: got %b want 0", dispatch_stall); end
   endtask

   task automatic test_freelist();
      fl_avail = 2'd1;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b11, 32'hB00);
      step(); idle();
      n_tests++; if (disp_valid !== 2'b01) begin n_fail++; $display("FAIL fl_valid: got %b want 01", disp_valid); end
      n_tests++; if (fl_pop_cnt !== 2'd1) begin n_fail++; $display("FAIL fl_pop: got %0d want 1", fl_pop_cnt); end
      step();
      rob_free_cnt = 6'd0;
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL fl_rob0: got %b want 00", disp_valid); end
      n_tests++; if (dispatch_stall !== 1'b1) begin n_fail++; $display("FAIL fl_rob0_stall: got %b want 1", dispatch_stall); end
      rob_free_cnt = 6'd8; fl_avail = 2'd0;
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL fl_zero: got %b want 00", disp_valid); end
      fl_avail = 2'd1;
      #1;
      n_tests++; if (disp_valid !== 2'b01) begin n_fail++; $display("FAIL fl_one: got %b want 01", disp_valid); end
      step();
      set_lanes(2'b11, 3'd1, 3'd1, 2'b10, 32'hC00);
      step(); idle();
      n_tests++; if (disp_valid !== 2'b11) begin n_fail++; $display("FAIL fl_mixed: got %b want 11", disp_valid); end
      n_tests++; if (fl_pop_cnt !== 2'd1) begin n_fail++; $display("FAIL fl_mixed_pop: got %0d want 1", fl_pop_cnt); end
      step();
      fl_avail = 2'd2;
   endtask

   task automatic test_reset_mid();
      rob_free_cnt = 6'd0;
      set_lanes(2'b11, 3'd1, 3'd1, 2'b11, 32'hD00);
      step(); idle();
      n_tests++; if (dispatch_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b want 1", dispatch_stall); end
      #1; rst_n = 1'b0; rob_free_cnt = 6'd8;
      #1;
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_valid: got %b want 00", disp_valid); end
      n_tests++; if (disp_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", disp_cnt); end
      n_tests++; if (fl_pop_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_flpop: got %0d want 0", fl_pop_cnt); end
      n_tests++; if (dispatch_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", dispatch_stall); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
      step();
      @(negedge clk); rst_n = 1'b1;
      step();
      n_tests++; if (disp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_after: got %b want 00", disp_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rob_wrap();
      test_credit();
      test_in_order();
      test_flush();
      test_freelist();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
      $fatal(1);
   end
endmodule
